// File: rtl/vscale_mul_div_if.sv
// Request/response channel between the execute stage and the iterative mul/div unit.
// The pipeline is the master; the mul/div unit is the slave.
interface vscale_mul_div_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_in1;
    logic [XLEN-1:0] req_in2;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_out;

    modport master (
        output req_valid, req_op, req_in1, req_in2, kill, resp_ready,
        input  req_ready, resp_valid, resp_out
    );

    modport slave (
        input  req_valid, req_op, req_in1, req_in2, kill, resp_ready,
        output req_ready, resp_valid, resp_out
    );
endinterface

// File: rtl/vscale_mul_div.sv
// Iterative radix-2 multiply/divide unit for the RISC-V M extension.
// Fixed latency of XLEN+2 cycles from accept to resp_valid for every op.
module vscale_mul_div #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    vscale_mul_div_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned DW    = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_COMPUTE,
        S_FINISH,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [XLEN-1:0]  in1_q, in2_q;
    logic [XLEN-1:0]  opnd;
    logic [DW-1:0]    acc;
    logic             neg, div0, ovf;
    logic [XLEN-1:0]  result;

    logic             req_ready_c, accept_c, last_c, is_div_c;
    logic             sgn1_c, sgn2_c, neg_c, div0_c, ovf_c;
    logic [XLEN-1:0]  mag1_c, mag2_c;
    logic [XLEN:0]    mul_sum_c, rem_sh_c;
    logic [XLEN-1:0]  rem_sub_c, rem_new_c;
    logic             div_ge_c;
    logic [DW-1:0]    mul_step_c, div_step_c, prod_f_c;
    logic [XLEN-1:0]  quo_c, rem_c, quo_f_c, rem_f_c, fin_c;

    assign req_ready_c    = (state == S_IDLE) && !bus.kill;
    assign accept_c       = bus.req_valid && req_ready_c;
    assign last_c         = (cnt == CNT_W'(XLEN - 1));
    assign is_div_c       = op_q[2];

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = (state == S_DONE);
    assign bus.resp_out   = result;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; kill aborts from every busy state and wins over resp_ready
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept_c) state_nxt = S_SETUP;
            S_SETUP:   state_nxt = bus.kill ? S_IDLE : S_COMPUTE;
            S_COMPUTE: begin
                if (bus.kill)    state_nxt = S_IDLE;
                else if (last_c) state_nxt = S_FINISH;
            end
            S_FINISH:  state_nxt = bus.kill ? S_IDLE : S_DONE;
            S_DONE:    if (bus.kill || bus.resp_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Operand signedness, magnitudes and result sign for the captured op
    always_comb begin
        sgn1_c = 1'b0;
        sgn2_c = 1'b0;
        case (op_q)
            OP_MULH, OP_DIV, OP_REM: begin
                sgn1_c = in1_q[XLEN-1];
                sgn2_c = in2_q[XLEN-1];
            end
            OP_MULHSU: sgn1_c = in1_q[XLEN-1];
            default: ;
        endcase
        mag1_c = sgn1_c ? (~in1_q + XLEN'(1)) : in1_q;
        mag2_c = sgn2_c ? (~in2_q + XLEN'(1)) : in2_q;
        div0_c = (in2_q == '0);
        ovf_c  = (in1_q == {1'b1, {(XLEN-1){1'b0}}}) && (in2_q == '1);
        neg_c  = sgn1_c ^ sgn2_c;
        if (op_q == OP_DIV) neg_c = (sgn1_c ^ sgn2_c) && !div0_c;
        if (op_q == OP_REM) neg_c = sgn1_c;
    end

    // One radix-2 step: shift-add multiply, restoring divide ({remainder, quotient} in acc)
    always_comb begin
        mul_sum_c  = {1'b0, acc[DW-1:XLEN]} + {1'b0, (acc[0] ? opnd : '0)};
        mul_step_c = {mul_sum_c, acc[XLEN-1:1]};
        rem_sh_c   = {acc[DW-1:XLEN], acc[XLEN-1]};
        div_ge_c   = (rem_sh_c >= {1'b0, opnd});
        rem_sub_c  = rem_sh_c[XLEN-1:0] - opnd;
        rem_new_c  = div_ge_c ? rem_sub_c : rem_sh_c[XLEN-1:0];
        div_step_c = {rem_new_c, acc[XLEN-2:0], div_ge_c};
    end

    // Sign fix-up and result selection, including forced special-case results
    always_comb begin
        prod_f_c = neg ? (~acc + DW'(1)) : acc;
        quo_c    = acc[XLEN-1:0];
        rem_c    = acc[DW-1:XLEN];
        quo_f_c  = neg ? (~quo_c + XLEN'(1)) : quo_c;
        rem_f_c  = neg ? (~rem_c + XLEN'(1)) : rem_c;
        fin_c    = '0;
        case (op_q)
            OP_MUL:                        fin_c = prod_f_c[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fin_c = prod_f_c[DW-1:XLEN];
            OP_DIV:  fin_c = div0 ? '1 : (ovf ? in1_q : quo_f_c);
            OP_DIVU: fin_c = div0 ? '1 : quo_c;
            OP_REM:  fin_c = div0 ? in1_q : (ovf ? '0 : rem_f_c);
            OP_REMU: fin_c = div0 ? in1_q : rem_c;
            default: fin_c = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            op_q   <= '0;
            in1_q  <= '0;
            in2_q  <= '0;
            opnd   <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        op_q  <= bus.req_op;
                        in1_q <= bus.req_in1;
                        in2_q <= bus.req_in2;
                    end
                end
                S_SETUP: begin
                    cnt  <= '0;
                    opnd <= is_div_c ? mag2_c : mag1_c;
                    acc  <= {{XLEN{1'b0}}, (is_div_c ? mag1_c : mag2_c)};
                    neg  <= neg_c;
                    div0 <= div0_c;
                    ovf  <= ovf_c;
                end
                S_COMPUTE: begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= is_div_c ? div_step_c : mul_step_c;
                end
                S_FINISH: begin
                    if (!bus.kill) result <= fin_c;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vscale_mul_div.sv
// Self-checking bench for vscale_mul_div: directed M-extension cases, kill/reset
// handling, backpressure, and randomized ops checked against an arithmetic model.
module tb_vscale_mul_div;
    localparam int unsigned XLEN = 32;
    localparam int unsigned LAT  = XLEN + 2;

    typedef struct {
        logic [31:0] res;
        int unsigned cyc;
    } exp_t;

    logic clk;
    logic reset_n;
    int unsigned cyc;
    int errors;
    int checks;
    exp_t exp_q[$];
    logic was_valid;

    vscale_mul_div_if #(.XLEN(XLEN)) bus ();

    vscale_mul_div #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic with the M-extension corner rules
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        r  = '0;
        case (op)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = 32'(sa / sb);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else r = 32'(sa % sb);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Compare process: value and latency of every valid response
    always @(negedge clk) begin
        if (reset_n && bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_resp_valid", 32'(bus.resp_valid), 32'h0);
            end else begin
                chk("resp_out", bus.resp_out, exp_q[0].res);
                if (!was_valid) chk("latency", cyc - exp_q[0].cyc, LAT);
                if (bus.resp_ready && !bus.kill) void'(exp_q.pop_front());
            end
        end
        was_valid = reset_n && bus.resp_valid;
    end

    // Drive a request (call between edges); returns polls spent waiting for req_ready
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, output int polls);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_in1   = a;
        bus.req_in2   = b;
        #1;
        polls = 0;
        while (!bus.req_ready && polls < 100) begin
            @(negedge clk);
            polls++;
        end
        if (!bus.req_ready) chk("req_ready_timeout", 32'(bus.req_ready), 32'h1);
        e.res = exp;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'($urandom_range(0, 7));
        bus.req_in1   = $urandom;
        bus.req_in2   = $urandom;
    endtask

    task automatic issue_lit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] lit);
        int polls;
        chk("model_pin", ref_result(op, a, b), lit);
        issue(op, a, b, lit, polls);
    endtask

    // Wait for the response, hold it off for 'hold' cycles, then take it
    task automatic take_resp(input int hold, input bit check_hold);
        int n;
        n = 0;
        while (!bus.resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.resp_valid) chk("resp_timeout", 32'(bus.resp_valid), 32'h1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (check_hold) begin
                chk("hold_req_ready", 32'(bus.req_ready), 32'h0);
                chk("hold_resp_valid", 32'(bus.resp_valid), 32'h1);
            end
        end
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("post_hs_req_ready", 32'(bus.req_ready), 32'h1);
    endtask

    task automatic run_lit(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lit);
        issue_lit(op, a, b, lit);
        take_resp(0, 1'b0);
    endtask

    task automatic quiet_window(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        chk(name, 32'(seen), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int polls;
        logic [2:0]  op;
        logic [31:0] a, b;
        int r;
        errors = 0;
        checks = 0;
        cyc = 0;
        was_valid = 1'b0;
        reset_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_in1 = '0;
        bus.req_in2 = '0;
        bus.kill = 1'b0;
        bus.resp_ready = 1'b0;
        #2;
        chk("reset_req_ready", 32'(bus.req_ready), 32'h1);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("reset_resp_out", bus.resp_out, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Multiply corner cases
        run_lit(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_lit(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_lit(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_lit(3'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
        // Divide
        run_lit(3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_lit(3'd6, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001);
        run_lit(3'd5, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
        run_lit(3'd7, 32'd100, 32'd7, 32'd2);
        // Divide by zero and signed overflow
        run_lit(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_lit(3'd7, 32'd5, 32'd0, 32'd5);
        run_lit(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_lit(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_lit(3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);

        // Backpressure, then a request right after the handshake
        issue_lit(3'd0, 32'd12345, 32'd678, 32'd8369910);
        take_resp(10, 1'b1);
        issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, ref_result(3'd3, 32'hDEAD_BEEF, 32'h1234_5678), polls);
        chk("back_to_back_accept_polls", 32'(polls), 32'h0);
        take_resp(0, 1'b0);

        // Kill mid-compute, then a fresh MUL
        issue_lit(3'd4, 32'd1000, 32'd3, 32'd333);
        repeat (11) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("kill_req_ready", 32'(bus.req_ready), 32'h1);
        quiet_window("kill_no_resp", 45);
        run_lit(3'd0, 32'd6, 32'd7, 32'd42);

        // Kill together with resp_ready in DONE drops the result
        issue_lit(3'd5, 32'd81, 32'd9, 32'd9);
        while (!bus.resp_valid) @(negedge clk);
        @(posedge clk);
        #1;
        bus.kill = 1'b1;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        bus.resp_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("kill_done_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("kill_done_req_ready", 32'(bus.req_ready), 32'h1);

        // Kill in IDLE blocks acceptance
        @(posedge clk);
        #1;
        bus.kill = 1'b1;
        bus.req_valid = 1'b1;
        @(negedge clk);
        chk("kill_idle_req_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("kill_idle_not_accepted", 32'(bus.req_ready), 32'h1);
        quiet_window("kill_idle_no_resp", 40);

        // Asynchronous reset between edges mid-compute
        issue_lit(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF);
        repeat (10) @(posedge clk);
        #3;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("async_rst_req_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        quiet_window("post_reset_no_resp", 40);
        run_lit(3'd4, 32'd100, 32'd10, 32'd10);

        // Randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0) b = 32'h0;
            if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (r == 2) b = 32'($urandom_range(1, 15));
            if (r == 3) a = 32'($urandom_range(0, 20));
            issue(op, a, b, ref_result(op, a, b), polls);
            take_resp(int'($urandom_range(0, 3)), 1'b0);
        end

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vscale_mul_div.md
Name: vscale_mul_div

Overview:
- Iterative, parametrised multiply/divide unit implementing the RISC-V M-extension operations.
- Sits beside the combinational vscale ALU in the execute stage.
- Accepts one operation at a time over a valid/ready request channel and returns the result over a valid/ready response channel after a fixed latency.
- The pipeline stalls on busy and can abort an in-flight operation with kill on flush or exception.

Parameters:
- XLEN, 32, operand and result width in bits (any even value ≥ 8).
- CNT_W, $clog2(XLEN), width of the iteration counter. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_op  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_in1  input  XLEN  rs1 operand (multiplicand / dividend).
- req_in2  input  XLEN  rs2 operand (multiplier / divisor).
- kill  input  1  abort the current operation.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes the result.
- resp_out  output  XLEN  result.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting reset_n low forces state IDLE immediately, without waiting for a clock edge.
  - Outputs under reset: req_ready=1, resp_valid=0, resp_out=0, counter=0. Datapath registers clear to 0.
  - Reset mid-operation discards the operation; no response is ever produced for it.
- States: IDLE, SETUP, COMPUTE, FINISH, DONE.
- Request ports:
  - req_ready = (state==IDLE) && !kill.
  - Accept occurs when req_valid && req_ready; op and operands are captured at that edge.
  - Input ports may change freely after accept.
- State sequence after accept at edge 0:
  - Edge 0: IDLE→SETUP.
  - Edge 1: SETUP→COMPUTE, counter=0. SETUP converts signed operands to magnitudes.
    - Signed: in1 for MULH, MULHSU, DIV, REM. in2 for MULH, DIV, REM.
    - MUL treats both operands as unsigned; its low half is sign-agnostic.
    - SETUP records the result sign:
      - Multiply: sign1 XOR sign2.
      - DIV: sign1 XOR sign2, but not for divide-by-zero.
      - REM: sign1.
  - Edges 2..XLEN+1: one radix-2 iteration per cycle.
    - Multiply: shift-add into a 2*XLEN product register.
    - Divide: restoring shift-subtract producing quotient and remainder.
    - The counter increments each cycle; at counter==XLEN-1, COMPUTE→FINISH.
  - Edge XLEN+2: FINISH→DONE. FINISH applies the two's-complement negation if the sign flag is set, then selects:
    - MUL: low XLEN bits.
    - MULH, MULHSU, MULHU: high XLEN bits.
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
  - Latency: resp_valid goes high XLEN+2 cycles after the accept edge (34 for XLEN=32), for every op including the special cases.
- Special cases (fixed latency, results forced in FINISH):
  - Divisor zero: DIV/DIVU → all ones; REM/REMU → in1 unchanged.
  - Signed overflow (in1 = most-negative value, in2 = all ones): DIV → in1; REM → 0.
- Response:
  - In DONE, resp_valid=1 and resp_out holds the registered result, stable until the handshake.
  - When resp_valid && resp_ready: DONE→IDLE; resp_valid drops the next cycle; req_ready rises the next cycle.
  - No same-cycle response/request overlap; minimum issue interval is XLEN+4 cycles.
  - resp_out keeps its last value in IDLE. Only resp_valid qualifies it.
- Kill:
  - kill in SETUP, COMPUTE, FINISH or DONE → IDLE at the next edge. resp_valid=0 from that edge on; no response is produced.
  - kill in DONE together with resp_ready: kill wins and the result is dropped.
  - kill in IDLE: blocks acceptance that cycle (req_ready=0); no other effect.
- All arithmetic is modulo 2^XLEN (2^(2*XLEN) for the product register). No X propagation from unused operand bits.

Test Plan:
- MULH 0x80000000 × 0x80000000; MULHSU 0xFFFFFFFF × 0xFFFFFFFF; MULHU 0xFFFFFFFF × 0xFFFFFFFF; MUL 0xFFFFFFFF × 3 (XLEN=32) → 0x40000000, 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFFD respectively. resp_valid asserts exactly 34 cycles after accept.
- DIV 7 / -2 → 0xFFFFFFFD; REM 7 / -2 → 0x00000001; DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF; REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0. Each takes 34 cycles.
- Response backpressure: hold resp_ready=0 for 10 cycles after resp_valid.
  - resp_out must stay stable and req_ready must stay 0.
  - Raise resp_ready: resp_valid falls and req_ready rises on the next edge.
  - A new request is accepted on the following cycle.
- Kill handling:
  - Pulse kill at COMPUTE iteration 10 → IDLE next edge and no resp_valid ever. A following MUL 6 × 7 returns 42 with full latency.
  - Assert kill and req_valid together in IDLE → request not accepted.
- Drive reset_n low asynchronously (between edges) mid-COMPUTE → resp_valid=0 and req_ready=1 immediately. After release, a new DIV 100 / 10 → 10.
